// File: rtl/ar_xbar_param_if.sv
// AXI read-address crossbar bundle: per-master AR/R-observe signals and per-slave AR/R-observe signals.
// Latency: n/a (wires only). Backpressure: carried by ARREADY_M / ARREADY_S.
// Modports: slave = crossbar view (masters' AR in, slaves' AR out); master = environment view driving both sides.
interface ar_xbar_param_if #(
  parameter int NUM_M   = 3,
  parameter int NUM_S   = 7,
  parameter int ID_W    = 4,
  parameter int MID_W   = $clog2(NUM_M),
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SIZE_W  = 3,
  parameter int BURST_W = 2
);
  // master side
  logic [NUM_M*ID_W-1:0]           ARID_M;
  logic [NUM_M*ADDR_W-1:0]         ARADDR_M;
  logic [NUM_M*LEN_W-1:0]          ARLEN_M;
  logic [NUM_M*SIZE_W-1:0]         ARSIZE_M;
  logic [NUM_M*BURST_W-1:0]        ARBURST_M;
  logic [NUM_M-1:0]                ARVALID_M;
  logic [NUM_M-1:0]                ARREADY_M;
  logic [NUM_M-1:0]                RVALID_M;
  logic [NUM_M-1:0]                RREADY_M;
  logic [NUM_M-1:0]                RLAST_M;
  // slave side
  logic [NUM_S*(MID_W+ID_W)-1:0]   ARID_S;
  logic [NUM_S*ADDR_W-1:0]         ARADDR_S;
  logic [NUM_S*LEN_W-1:0]          ARLEN_S;
  logic [NUM_S*SIZE_W-1:0]         ARSIZE_S;
  logic [NUM_S*BURST_W-1:0]        ARBURST_S;
  logic [NUM_S-1:0]                ARVALID_S;
  logic [NUM_S-1:0]                ARREADY_S;
  logic [NUM_S-1:0]                RVALID_S;
  logic [NUM_S-1:0]                RREADY_S;
  logic [NUM_S-1:0]                RLAST_S;

  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    input  RVALID_M, RREADY_M, RLAST_M,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S, RVALID_S, RREADY_S, RLAST_S
  );

  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    output RVALID_M, RREADY_M, RLAST_M,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S, RVALID_S, RREADY_S, RLAST_S
  );
endinterface

// File: rtl/ar_xbar_param.sv
// AXI AR crossbar NUM_M->NUM_S: arbitrate, decode address, route, prefix master index onto ARID.
// Latency: zero-cycle combinational forward of the winning request; busy bits update next cycle.
// Backpressure: ARREADY_M follows the selected slave's ARREADY, masked while that slave or master has a burst open.
// Ports: clk, rst (async, active-high), bus (ar_xbar_param_if.slave: per-master AR + R observe, per-slave AR + R observe).
// Option: define AR_RR_ARB_EN for round-robin arbitration; default is fixed priority (master 0 highest).
module ar_xbar_param #(
  parameter int NUM_M   = 3,
  parameter int NUM_S   = 7,
  parameter int ID_W    = 4,
  parameter int MID_W   = $clog2(NUM_M),
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SIZE_W  = 3,
  parameter int BURST_W = 2,
  parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
                                                 32'h0003_0000, 32'h0002_0000, 32'h0001_0000,
                                                 32'h0000_0000},
  parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {NUM_S{32'hFFFF_0000}},
  parameter int DEF_SLV = NUM_S - 1
) (
  input logic             clk,
  input logic             rst,
  ar_xbar_param_if.slave  bus
);
  localparam int SEL_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;
  localparam int SID_W = MID_W + ID_W;

  typedef enum logic {S_IDLE, S_HOLD} state_e;

  state_e              state_q, state_d;
  logic [MID_W-1:0]    gnt_q, gnt_d;
  logic [NUM_M-1:0]    m_busy_q, m_busy_d;
  logic [NUM_S-1:0]    s_busy_q, s_busy_d;
`ifdef AR_RR_ARB_EN
  logic [MID_W-1:0]    rr_ptr_q, rr_ptr_d;
`endif

  logic [NUM_M-1:0]    elig;
  logic [MID_W-1:0]    arb_idx, gnt;
  logic                gnt_vld, fwd, hs;
  logic [SEL_W-1:0]    sel;
  logic [ID_W-1:0]     g_id;
  logic [ADDR_W-1:0]   g_addr;
  logic [LEN_W-1:0]    g_len;
  logic [SIZE_W-1:0]   g_size;
  logic [BURST_W-1:0]  g_burst;
  logic [NUM_M-1:0]    arready_m;
  logic [NUM_S-1:0]    arvalid_s;

  // Lowest-index match wins; iterate downward so the lowest match is written last.
  function automatic logic [SEL_W-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [SEL_W-1:0] s;
    s = SEL_W'(DEF_SLV);
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if ((a & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) s = SEL_W'(i);
    end
    return s;
  endfunction

`ifdef AR_RR_ARB_EN
  // First requester at or after ptr, wrapping; nearest-to-ptr is written last.
  function automatic logic [MID_W-1:0] pick(input logic [NUM_M-1:0] req, input logic [MID_W-1:0] ptr);
    logic [MID_W-1:0] idx;
    int               j;
    idx = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_M) j = j - NUM_M;
      if (req[j]) idx = MID_W'(j);
    end
    return idx;
  endfunction
`else
  function automatic logic [MID_W-1:0] pick(input logic [NUM_M-1:0] req);
    logic [MID_W-1:0] idx;
    idx = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      if (req[k]) idx = MID_W'(k);
    end
    return idx;
  endfunction
`endif

  always_comb begin
    elig = bus.ARVALID_M & ~m_busy_q;
`ifdef AR_RR_ARB_EN
    arb_idx = pick(elig, rr_ptr_q);
`else
    arb_idx = pick(elig);
`endif
    // In HOLD the locked master cannot be busy: its busy bit is only set by its own handshake.
    gnt     = (state_q == S_HOLD) ? gnt_q : arb_idx;
    gnt_vld = (state_q == S_HOLD) ? bus.ARVALID_M[gnt_q] : |elig;

    g_id    = bus.ARID_M[int'(gnt)*ID_W +: ID_W];
    g_addr  = bus.ARADDR_M[int'(gnt)*ADDR_W +: ADDR_W];
    g_len   = bus.ARLEN_M[int'(gnt)*LEN_W +: LEN_W];
    g_size  = bus.ARSIZE_M[int'(gnt)*SIZE_W +: SIZE_W];
    g_burst = bus.ARBURST_M[int'(gnt)*BURST_W +: BURST_W];
    sel     = decode(g_addr);

    // rst gates the forward path so nothing is offered while reset is asserted.
    fwd = gnt_vld & ~s_busy_q[sel] & ~rst;
    hs  = fwd & bus.ARREADY_S[sel];

    for (int i = 0; i < NUM_S; i++) arvalid_s[i] = fwd & (sel == SEL_W'(i));
    for (int m = 0; m < NUM_M; m++) arready_m[m] = hs & (gnt == MID_W'(m));

    // Busy tracking: set on AR handshake, clear on final R beat; set is masked by busy so no overlap.
    m_busy_d = (hs ? (NUM_M'(1) << gnt) : '0) | (m_busy_q & ~(bus.RVALID_M & bus.RREADY_M & bus.RLAST_M));
    s_busy_d = (hs ? (NUM_S'(1) << sel) : '0) | (s_busy_q & ~(bus.RVALID_S & bus.RREADY_S & bus.RLAST_S));

    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      S_IDLE: if (gnt_vld && !hs) begin
        state_d = S_HOLD;
        gnt_d   = arb_idx;
      end
      S_HOLD: if (hs || !gnt_vld) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef AR_RR_ARB_EN
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = (int'(gnt) == NUM_M - 1) ? '0 : gnt + 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      m_busy_q <= '0;
      s_busy_q <= '0;
`ifdef AR_RR_ARB_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      m_busy_q <= m_busy_d;
      s_busy_q <= s_busy_d;
`ifdef AR_RR_ARB_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign bus.ARREADY_M = arready_m;
  assign bus.ARVALID_S = arvalid_s;
  assign bus.ARID_S    = {NUM_S{gnt, g_id}};
  assign bus.ARADDR_S  = {NUM_S{g_addr}};
  assign bus.ARLEN_S   = {NUM_S{g_len}};
  assign bus.ARSIZE_S  = {NUM_S{g_size}};
  assign bus.ARBURST_S = {NUM_S{g_burst}};
endmodule

// File: tb/tb_ar_xbar_param.sv
module tb_ar_xbar_param;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  ar_xbar_param_if bus ();
  ar_xbar_param dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_m(input int m, input logic v, input logic [31:0] a, input logic [3:0] len);
    bus.ARVALID_M[m] = v;
    bus.ARADDR_M[m*32 +: 32] = a;
    bus.ARLEN_M[m*4 +: 4] = len;
  endtask

  task automatic clear_r();
    bus.RVALID_M = '0; bus.RREADY_M = '0; bus.RLAST_M = '0;
    bus.RVALID_S = '0; bus.RREADY_S = '0; bus.RLAST_S = '0;
  endtask

  // one clock of final-beat R handshakes on the given masters/slaves
  task automatic pulse_r(input logic [2:0] mm, input logic [6:0] sm);
    @(negedge clk);
    bus.RVALID_M = mm; bus.RREADY_M = mm; bus.RLAST_M = mm;
    bus.RVALID_S = sm; bus.RREADY_S = sm; bus.RLAST_S = sm;
    @(negedge clk);
    clear_r();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ARID_M = {4'h3, 4'h5, 4'hA};
    bus.ARSIZE_M = '0; bus.ARBURST_M = '0; bus.ARLEN_M = '0;
    bus.ARREADY_S = '1;
    clear_r();
    set_m(0, 1'b1, 32'h0000_0100, 4'd0);
    set_m(1, 1'b1, 32'h0001_0000, 4'd0);
    set_m(2, 1'b1, 32'h0002_0000, 4'd0);
    @(negedge clk); @(negedge clk); #1;
    tests++; if (bus.ARREADY_M !== 3'b000) begin fails++; $display("FAIL rst_arready got=%b exp=000", bus.ARREADY_M); end
    tests++; if (bus.ARVALID_S !== 7'b0) begin fails++; $display("FAIL rst_arvalid got=%b exp=0000000", bus.ARVALID_S); end
    @(negedge clk); rst = 1'b0; #1;
    tests++; if (bus.ARVALID_S !== 7'b0000001) begin fails++; $display("FAIL post_rst_arvalid got=%b exp=0000001", bus.ARVALID_S); end
    tests++; if (bus.ARREADY_M !== 3'b001) begin fails++; $display("FAIL post_rst_arready got=%b exp=001", bus.ARREADY_M); end
    tests++; if (bus.ARID_S[0 +: 6] !== 6'h0A) begin fails++; $display("FAIL post_rst_arid got=%h exp=0a", bus.ARID_S[0 +: 6]); end
    @(negedge clk);
    bus.ARVALID_M = '0;
    pulse_r(3'b001, 7'b0000001);
  endtask

  task automatic test_hold();
    bus.ARREADY_S = '0;
    @(negedge clk); set_m(1, 1'b1, 32'h0001_0000, 4'd0); #1;
    tests++; if (bus.ARVALID_S !== 7'b0000010) begin fails++; $display("FAIL hold_c0_arvalid got=%b exp=0000010", bus.ARVALID_S); end
    tests++; if (bus.ARREADY_M !== 3'b000) begin fails++; $display("FAIL hold_c0_arready got=%b exp=000", bus.ARREADY_M); end
    @(negedge clk); set_m(0, 1'b1, 32'h0000_0000, 4'd0); #1;
    tests++; if (bus.ARVALID_S !== 7'b0000010) begin fails++; $display("FAIL hold_c1_arvalid got=%b exp=0000010", bus.ARVALID_S); end
    tests++; if (bus.ARID_S[6 +: 6] !== 6'h15) begin fails++; $display("FAIL hold_c1_arid got=%h exp=15", bus.ARID_S[6 +: 6]); end
    @(negedge clk); #1;
    tests++; if (bus.ARADDR_S[0 +: 32] !== 32'h0001_0000) begin fails++; $display("FAIL hold_c2_fanout got=%h exp=00010000", bus.ARADDR_S[0 +: 32]); end
    @(negedge clk); bus.ARREADY_S = 7'b0000011; #1;
    tests++; if (bus.ARREADY_M !== 3'b010) begin fails++; $display("FAIL hold_c3_arready got=%b exp=010", bus.ARREADY_M); end
    @(negedge clk); set_m(1, 1'b0, 32'h0001_0000, 4'd0); #1;
    tests++; if (bus.ARVALID_S !== 7'b0000001) begin fails++; $display("FAIL hold_next_arvalid got=%b exp=0000001", bus.ARVALID_S); end
    tests++; if (bus.ARREADY_M !== 3'b001) begin fails++; $display("FAIL hold_next_arready got=%b exp=001", bus.ARREADY_M); end
    tests++; if (bus.ARID_S[0 +: 6] !== 6'h0A) begin fails++; $display("FAIL hold_next_arid got=%h exp=0a", bus.ARID_S[0 +: 6]); end
    @(negedge clk); set_m(0, 1'b0, 32'h0, 4'd0);
    pulse_r(3'b011, 7'b0000011);
  endtask

  task automatic test_slave_busy();
    @(negedge clk); bus.ARREADY_S = '1; set_m(0, 1'b1, 32'h0002_0000, 4'd3); #1;
    tests++; if (bus.ARVALID_S !== 7'b0000100) begin fails++; $display("FAIL sbusy_first_arvalid got=%b exp=0000100", bus.ARVALID_S); end
    tests++; if (bus.ARLEN_S[8 +: 4] !== 4'd3) begin fails++; $display("FAIL sbusy_arlen got=%0d exp=3", bus.ARLEN_S[8 +: 4]); end
    @(negedge clk); set_m(0, 1'b0, 32'h0, 4'd0); set_m(2, 1'b1, 32'h0002_0040, 4'd0); #1;
    tests++; if (bus.ARVALID_S !== 7'b0) begin fails++; $display("FAIL sbusy_blocked_arvalid got=%b exp=0000000", bus.ARVALID_S); end
    tests++; if (bus.ARREADY_M !== 3'b000) begin fails++; $display("FAIL sbusy_blocked_arready got=%b exp=000", bus.ARREADY_M); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.RVALID_S[2] = 1'b1; bus.RREADY_S[2] = 1'b1; bus.RLAST_S[2] = (b == 3);
      bus.RVALID_M[0] = 1'b1; bus.RREADY_M[0] = 1'b1; bus.RLAST_M[0] = (b == 3);
      #1;
      tests++; if (bus.ARVALID_S !== 7'b0) begin fails++; $display("FAIL sbusy_beat%0d_arvalid got=%b exp=0000000", b, bus.ARVALID_S); end
    end
    @(negedge clk); clear_r(); #1;
    tests++; if (bus.ARVALID_S !== 7'b0000100) begin fails++; $display("FAIL sbusy_after_arvalid got=%b exp=0000100", bus.ARVALID_S); end
    tests++; if (bus.ARREADY_M !== 3'b100) begin fails++; $display("FAIL sbusy_after_arready got=%b exp=100", bus.ARREADY_M); end
    tests++; if (bus.ARID_S[12 +: 6] !== 6'h23) begin fails++; $display("FAIL sbusy_after_arid got=%h exp=23", bus.ARID_S[12 +: 6]); end
    @(negedge clk); set_m(2, 1'b0, 32'h0, 4'd0);
    pulse_r(3'b100, 7'b0000100);
  endtask

  task automatic test_default();
    @(negedge clk); bus.ARREADY_S = '1; set_m(2, 1'b1, 32'hFFFF_0000, 4'd0); #1;
    tests++; if (bus.ARVALID_S !== 7'b1000000) begin fails++; $display("FAIL def_arvalid got=%b exp=1000000", bus.ARVALID_S); end
    tests++; if (bus.ARID_S[36 +: 6] !== 6'h23) begin fails++; $display("FAIL def_arid got=%h exp=23", bus.ARID_S[36 +: 6]); end
    tests++; if (bus.ARADDR_S[192 +: 32] !== 32'hFFFF_0000) begin fails++; $display("FAIL def_araddr got=%h exp=ffff0000", bus.ARADDR_S[192 +: 32]); end
    @(negedge clk); set_m(2, 1'b0, 32'h0, 4'd0);
    pulse_r(3'b100, 7'b1000000);
  endtask

  task automatic test_master_busy();
    @(negedge clk); bus.ARREADY_S = '1; set_m(0, 1'b1, 32'h0000_0000, 4'd0); #1;
    tests++; if (bus.ARREADY_M !== 3'b001) begin fails++; $display("FAIL mbusy_first_arready got=%b exp=001", bus.ARREADY_M); end
    @(negedge clk); set_m(0, 1'b1, 32'h0003_0000, 4'd0); set_m(1, 1'b1, 32'h0004_0000, 4'd0); #1;
    tests++; if (bus.ARREADY_M !== 3'b010) begin fails++; $display("FAIL mbusy_m1_arready got=%b exp=010", bus.ARREADY_M); end
    tests++; if (bus.ARVALID_S !== 7'b0010000) begin fails++; $display("FAIL mbusy_m1_arvalid got=%b exp=0010000", bus.ARVALID_S); end
    @(negedge clk); set_m(1, 1'b0, 32'h0, 4'd0); #1;
    tests++; if (bus.ARREADY_M !== 3'b000) begin fails++; $display("FAIL mbusy_wait_arready got=%b exp=000", bus.ARREADY_M); end
    tests++; if (bus.ARVALID_S !== 7'b0) begin fails++; $display("FAIL mbusy_wait_arvalid got=%b exp=0000000", bus.ARVALID_S); end
    @(negedge clk);
    bus.RVALID_M[0] = 1'b1; bus.RREADY_M[0] = 1'b1; bus.RLAST_M[0] = 1'b1;
    bus.RVALID_S[0] = 1'b1; bus.RREADY_S[0] = 1'b1; bus.RLAST_S[0] = 1'b1;
    #1;
    tests++; if (bus.ARREADY_M !== 3'b000) begin fails++; $display("FAIL mbusy_rlast_arready got=%b exp=000", bus.ARREADY_M); end
    @(negedge clk); clear_r(); #1;
    tests++; if (bus.ARVALID_S !== 7'b0001000) begin fails++; $display("FAIL mbusy_reissue_arvalid got=%b exp=0001000", bus.ARVALID_S); end
    tests++; if (bus.ARREADY_M !== 3'b001) begin fails++; $display("FAIL mbusy_reissue_arready got=%b exp=001", bus.ARREADY_M); end
    @(negedge clk); set_m(0, 1'b0, 32'h0, 4'd0);
    pulse_r(3'b011, 7'b0011000);
  endtask

  task automatic test_arb_order();
    logic [2:0] exp_g [4];
    logic [2:0] prev;
`ifdef AR_RR_ARB_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_g = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
    @(negedge clk); rst = 1'b1; bus.ARVALID_M = '0; clear_r(); bus.ARREADY_S = '1;
    @(negedge clk); rst = 1'b0;
    prev = 3'b000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      set_m(0, 1'b1, 32'h0000_0000, 4'd0);
      set_m(1, 1'b1, 32'h0001_0000, 4'd0);
      set_m(2, 1'b1, 32'h0002_0000, 4'd0);
      // close the previous winner's single-beat burst on its master and its slave (slave index == master index)
      bus.RVALID_M = prev; bus.RREADY_M = prev; bus.RLAST_M = prev;
      bus.RVALID_S = {4'b0, prev}; bus.RREADY_S = {4'b0, prev}; bus.RLAST_S = {4'b0, prev};
      #1;
      tests++; if (bus.ARREADY_M !== exp_g[c]) begin fails++; $display("FAIL arb_order_%0d got=%b exp=%b", c, bus.ARREADY_M, exp_g[c]); end
      prev = exp_g[c];
    end
    @(negedge clk); bus.ARVALID_M = '0; clear_r();
    pulse_r(3'b111, 7'b1111111);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_hold();
    test_slave_busy();
    test_default();
    test_master_busy();
    test_arb_order();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ar_xbar_param.md
Name: ar_xbar_param

Overview:
- Parametrised AXI read-address crossbar: NUM_M masters to NUM_S slaves.
- Arbitrates AR requests (fixed priority, or round-robin when enabled), decodes the address against a parametrised slave map and routes the request.
- Prefixes the winning master index onto ARID.
- Tracks one outstanding read burst per master and per slave, releasing each on the final R beat.
- Sits in the AXI interconnect between CPU/DMA masters and memory/peripheral slaves.

Parameters:
- NUM_M, 3, number of masters (≥2)
- NUM_S, 7, number of slaves (≥2)
- ID_W, 4, master-side ARID width
- MID_W, $clog2(NUM_M), master index bits prepended to slave-side ARID
- ADDR_W, 32, address width
- LEN_W, 4, ARLEN width
- SIZE_W, 3, ARSIZE width
- BURST_W, 2, ARBURST width
- SLV_BASE, NUM_S*ADDR_W packed, base address per slave (slave i at bits [i*ADDR_W +: ADDR_W])
- SLV_MASK, NUM_S*ADDR_W packed, compare mask per slave
- DEF_SLV, NUM_S-1, slave index used when no region matches

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ARID_M  in  NUM_M*ID_W  per-master ARID
- ARADDR_M  in  NUM_M*ADDR_W  per-master ARADDR
- ARLEN_M  in  NUM_M*LEN_W  per-master ARLEN
- ARSIZE_M  in  NUM_M*SIZE_W  per-master ARSIZE
- ARBURST_M  in  NUM_M*BURST_W  per-master ARBURST
- ARVALID_M  in  NUM_M  per-master ARVALID
- ARREADY_M  out  NUM_M  per-master ARREADY
- RVALID_M, RREADY_M, RLAST_M  in  NUM_M each  master-side R handshake observation
- ARID_S  out  NUM_S*(MID_W+ID_W)  per-slave ARID, {master_idx, ARID}
- ARADDR_S  out  NUM_S*ADDR_W  per-slave ARADDR
- ARLEN_S  out  NUM_S*LEN_W  per-slave ARLEN
- ARSIZE_S  out  NUM_S*SIZE_W  per-slave ARSIZE
- ARBURST_S  out  NUM_S*BURST_W  per-slave ARBURST
- ARVALID_S  out  NUM_S  per-slave ARVALID
- ARREADY_S  in  NUM_S  per-slave ARREADY
- RVALID_S, RREADY_S, RLAST_S  in  NUM_S each  slave-side R handshake observation

Behaviour:
- Reset (async, rst=1): state IDLE, grant index 0, RR pointer 0, all m_busy/s_busy cleared, ARREADY_M=0, ARVALID_S=0. Reset mid-burst drops the grant and all busy bits immediately.
- Eligible master m: ARVALID_M[m] & ~m_busy[m].
- Decode: slave i matches when (addr & SLV_MASK_i) == SLV_BASE_i. Lowest matching index wins. No match selects DEF_SLV.
- Payload fan-out: ARID/ADDR/LEN/SIZE/BURST of the granted master drive all slave ports; only the decoded slave sees ARVALID.
- ARVALID_S[sel] = granted ARVALID & ~s_busy[sel].
- ARREADY_M[g] = ARREADY_S[sel] & ~s_busy[sel] & ~m_busy[g]. Zero-cycle combinational path, no added latency.
- FSM IDLE:
  - Winner chosen combinationally among eligible masters and forwarded in the same cycle.
  - Handshake (ARVALID_S & ARREADY_S) that cycle: stay IDLE, set m_busy[winner] and s_busy[sel].
  - Valid without handshake: go to HOLD, registering the winner index.
- FSM HOLD:
  - Granted master stays locked regardless of other requests (AXI stability).
  - Handshake: set busy bits, return to IDLE.
- Busy release:
  - s_busy[i] clears on RVALID_S[i] & RREADY_S[i] & RLAST_S[i].
  - m_busy[m] clears on RVALID_M[m] & RREADY_M[m] & RLAST_M[m].
  - Next value = set | (busy & ~release). Same-cycle set and release of one bit cannot occur, because set is masked by current busy.
- Target slave busy while granted: ARVALID_S held low and ARREADY_M low; the master waits in HOLD (or IDLE re-arbitration).
- Default arbitration is fixed priority, lowest index highest.
- No combinational path from R inputs to AR outputs except through busy registers (next cycle).

Optional Feature:
- AR_RR_ARB_EN
- Defined: round-robin arbitration. Search starts at rr_ptr. On each AR handshake, rr_ptr <= winner+1, wrapping from NUM_M-1 to 0. rr_ptr holds otherwise.
- Undefined: fixed priority, master 0 highest. rr_ptr logic is absent.

Test Plan:
- Reset with ARVALID_M=3'b111 asserted → ARREADY_M=0, ARVALID_S=0; after rst deasserts, M0 granted and ARID_S = {2'd0, ARID}.
- M1 reads 0x0001_0000 (slave 1 region), slave ARREADY delayed 3 cycles, M0 raises valid at cycle 1 → grant stays on M1 (HOLD); M1 accepted at cycle 3; M0 served next.
- M0 burst ARLEN=3 accepted to slave 2; M2 requests slave 2 → ARVALID_S[2] stays 0 until the RLAST beat handshake, then M2 is accepted in the following cycle.
- Unmapped address 0xFFFF_0000 from M2 → routed to DEF_SLV=6 with ARID_S[6] = {2'd2, ARID}.
- With AR_RR_ARB_EN, all three masters continuously valid, fast slaves → grant order 0,1,2,0; without the macro → M0 is re-granted each time its burst completes.
- M0 m_busy: second ARVALID from M0 while its R burst is pending → ARREADY_M[0]=0, and M1 is granted instead.
